// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: frame-level iteration controller for the layered LDPC core.
// Accepts one frame, pulses the core load, runs one iteration per cycle until
// the syndrome clears or the iteration limit is hit, then presents the result.
// Optional feature macro: LDPC_EARLY_TERM_EN (clean syndrome stops decoding early).
module ldpc_iter_ctrl #(
    parameter int R        = 32,
    parameter int C        = 16,
    parameter int D        = 64,
    parameter int MAX_ITER = 32,
    parameter int ITER_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [R*D-1:0]      in_sig,
    output logic [R*D-1:0]      dp_sig,
    output logic                dp_load,
    output logic                dp_run,
    input  logic [R*D-1:0]      dp_dec,
    input  logic                dp_check,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [R*D-1:0]      out_res,
    output logic                out_err,
    output logic [ITER_W-1:0]   out_iters,
    output logic                busy
);

    // Reject configurations the counter cannot represent at elaboration time.
    if (MAX_ITER < 1 || MAX_ITER > (2**ITER_W) - 1 || C < 1 || R < 1 || D < 1) begin : g_param_err
        $error("ldpc_iter_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ITER_W-1:0] iter_cnt;
    logic              at_max;
    logic              term;

    assign at_max = (iter_cnt == ITER_W'(MAX_ITER));

`ifdef LDPC_EARLY_TERM_EN
    // The core has no decisions before its first iteration, so a clean
    // syndrome only counts once at least one iteration has run.
    assign term = at_max | ((iter_cnt != '0) & ~dp_check);
`else
    assign term = at_max;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and state-decoded handshake/control outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        dp_load   = 1'b0;
        dp_run    = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) state_d = LOAD;
            end
            LOAD: begin
                dp_load = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (term) state_d = DONE;
                else      dp_run  = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Frame capture, iteration counting and result capture at stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_sig    <= '0;
            iter_cnt  <= '0;
            out_res   <= '0;
            out_err   <= 1'b0;
            out_iters <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) dp_sig <= in_sig;
                LOAD: iter_cnt <= '0;
                RUN: begin
                    if (term) begin
                        out_res   <= dp_dec;
                        out_err   <= dp_check;
                        out_iters <= iter_cnt;
                    end else begin
                        iter_cnt  <= iter_cnt + ITER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Randomized scoreboard bench for ldpc_iter_ctrl with a behavioural core model.
module tb_ldpc_iter_ctrl;

    localparam int R  = 2;
    localparam int C  = 4;
    localparam int D  = 16;
    localparam int FW = R * D;
    localparam int IW = 6;
`ifdef LDPC_EARLY_TERM_EN
    localparam int MAXI  = 32;
    localparam bit EARLY = 1'b1;
`else
    localparam int MAXI  = 4;
    localparam bit EARLY = 1'b0;
`endif
    localparam int RST_AT = (MAXI > 5) ? 5 : MAXI - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [FW-1:0] in_sig, dp_sig, dp_dec, out_res;
    logic          dp_load, dp_run, dp_check;
    logic          out_valid, out_ready, out_err, busy;
    logic [IW-1:0] out_iters;

    ldpc_iter_ctrl #(.R(R), .C(C), .D(D), .MAX_ITER(MAXI), .ITER_W(IW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sig(in_sig),
        .dp_sig(dp_sig), .dp_load(dp_load), .dp_run(dp_run),
        .dp_dec(dp_dec), .dp_check(dp_check),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_err(out_err), .out_iters(out_iters),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Core model: counts executed iterations; syndrome is nonzero until
    // conv_at iterations have run; decisions are a scramble of frame and count.
    function automatic logic [FW-1:0] mix(input int n);
        return 32'h9E3779B9 * 32'(n);
    endfunction

    int core_it = 0;
    int conv_at = 0;
    always @(posedge clk) begin
        if (dp_load)     core_it <= 0;
        else if (dp_run) core_it <= core_it + 1;
    end
    assign dp_check = (core_it < conv_at);
    assign dp_dec   = dp_sig ^ mix(core_it);

    typedef struct {
        logic [FW-1:0] res;
        logic          err;
        int            iters;
    } exp_t;
    exp_t sb[$];

    // Reference: decoding stops at the first iteration count n >= 1 with a
    // clean syndrome (if early stop is on), never beyond the limit.
    function automatic exp_t model(input logic [FW-1:0] f, input int conv);
        exp_t e;
        int n;
        if (EARLY) n = (conv < 1) ? 1 : conv;
        else       n = MAXI;
        if (n > MAXI) n = MAXI;
        e.iters = n;
        e.err   = (n < conv);
        e.res   = f ^ mix(n);
        return e;
    endfunction

    // Monitor: per-frame load/run counts, latency, hold stability, result compare.
    int            acc_cyc, first_ov, n_load, n_run;
    bit            ov_prev = 1'b0;
    logic [FW-1:0] h_res;
    logic          h_err;
    logic [IW-1:0] h_iters;
    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
            n_load  = 0;
            n_run   = 0;
        end else begin
            if (in_valid && in_ready) begin
                acc_cyc = cyc; n_load = 0; n_run = 0;
            end
            if (dp_load) n_load++;
            if (dp_run)  n_run++;
            if (out_valid) begin
                chk("in_ready_low_in_done", in_ready, 0);
                chk("busy_in_done", busy, 1);
                if (!ov_prev) begin
                    first_ov = cyc; h_res = out_res; h_err = out_err; h_iters = out_iters;
                end else begin
                    chk("hold_res", out_res, h_res);
                    chk("hold_err", out_err, h_err);
                    chk("hold_iters", out_iters, h_iters);
                end
                if (out_ready) begin
                    ov_prev = 1'b0;
                    if (sb.size() == 0) chk("unexpected_out", 1, 0);
                    else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("out_res", out_res, e.res);
                        chk("out_err", out_err, e.err);
                        chk("out_iters", out_iters, e.iters);
                        chk("run_cycles", n_run, e.iters);
                        chk("load_pulses", n_load, 1);
                        chk("latency", first_ov - acc_cyc, e.iters + 3);
                    end
                end else begin
                    ov_prev = 1'b1;
                end
            end
        end
    end

    // Issue one frame; bp holds out_ready low for 10 cycles in DONE while
    // throwing ignored in_valid pulses at the controller.
    task automatic run_frame(input logic [FW-1:0] f, input int conv, input bit bp);
        int n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) begin chk("accept_timeout", 0, 1); return; end
        in_sig = f; in_valid = 1'b1; conv_at = conv; out_ready = !bp;
        sb.push_back(model(f, conv));
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        if (!out_valid) begin chk("out_valid_timeout", 0, 1); return; end
        if (bp) begin
            repeat (10) begin
                in_valid = 1'($urandom);
                in_sig   = $urandom;
                @(negedge clk);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        if (bp) chk("b2b_in_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sig = '0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_dp_load", dp_load, 0);
        chk("reset_dp_run", dp_run, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_out_err", out_err, 0);
        chk("reset_out_iters", out_iters, 0);
        chk("reset_out_res", out_res, 0);
        chk("reset_dp_sig", dp_sig, 0);

        run_frame(32'hA5A5_0F0F, 3, 1'b0);          // early convergence
        run_frame(32'h1234_5678, 1000, 1'b0);       // never converges
        run_frame(32'hDEAD_BEEF, 0, 1'b0);          // clean syndrome at zero
        run_frame(32'h0BAD_F00D, 1, 1'b0);
        run_frame(32'hCAFE_0001, MAXI, 1'b0);       // converges exactly at limit
        run_frame(32'h5555_AAAA, 2, 1'b1);          // backpressure, then back-to-back
        run_frame(32'h7777_0000, MAXI + 1, 1'b0);
        for (int i = 0; i < 20; i++)
            run_frame($urandom, $urandom_range(0, MAXI + 3), ($urandom_range(0, 3) == 0));

        // Reset during RUN abandons the frame.
        run_frame_reset();

        // The controller must still work after the abandoned frame.
        run_frame(32'h0123_4567, 2, 1'b0);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    task automatic run_frame_reset();
        int k = 0;
        int n = 0;
        bit saw_ov = 1'b0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        in_sig = 32'hFACE_B00C; in_valid = 1'b1; conv_at = 1000; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (k < RST_AT && n < 200) begin
            if (dp_run) k++;
            if (k < RST_AT) @(negedge clk);
            n++;
        end
        chk("reset_iters_reached", k, RST_AT);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_dp_run", dp_run, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_err", out_err, 0);
        chk("midrst_out_iters", out_iters, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_busy", busy, 0);
        repeat (MAXI + 8) begin
            if (out_valid) saw_ov = 1'b1;
            @(negedge clk);
        end
        chk("postrst_no_out_valid", saw_ov, 0);
    endtask

endmodule

// File: doc/ldpc_iter_ctrl.md
# ldpc_iter_ctrl

Frame-level iteration controller for the layered LDPC decoder core. It accepts one received frame through a valid/ready handshake and holds that frame's sign bits for the datapath. It pulses the core's load, then enables one decoding iteration per cycle, watching the parity-check result. It stops on a satisfied syndrome or on the iteration limit, and presents the hard decisions, error flag and iteration count through an output valid/ready handshake.

## Interface
Parameters:
- `R`, 32, rows per circulant column (block rows).
- `C`, 16, circulant columns.
- `D`, 64, circulant size; frame width is `R*D` bits.
- `MAX_ITER`, 32, iteration limit; legal range 1 .. 2^`ITER_W`-1.
- `ITER_W`, 6, width of the iteration counter and `out_iters`.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input frame valid.
- `in_ready` out 1: controller can accept a frame.
- `in_sig` in `R*D`: received frame sign bits.
- `dp_sig` out `R*D`: registered frame driven to the core's channel input.
- `dp_load` out 1: one-cycle pulse; the core loads `dp_sig` and clears its messages.
- `dp_run` out 1: the core performs one iteration at this clock edge.
- `dp_dec` in `R*D`: core hard decisions; valid whenever `dp_run` is low.
- `dp_check` in 1: syndrome nonzero (1 = parity failed), consistent with `dp_dec`.
- `out_valid` out 1: result frame valid.
- `out_ready` in 1: downstream accepts the result.
- `out_res` out `R*D`: decoded frame.
- `out_err` out 1: frame not converged (parity still failing at stop).
- `out_iters` out `ITER_W`: iterations executed for this frame.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. `in_ready`, `dp_load`, `dp_run`, `out_valid` and `busy` are decoded from state.
- IDLE: `in_ready`=1. On `in_valid`: capture `in_sig` into `dp_sig` and move to LOAD.
- LOAD: `dp_load`=1 for exactly one cycle, `iter_cnt`←0, move to RUN.
- RUN: the stop condition is `term = (iter_cnt==MAX_ITER) | (iter_cnt!=0 & !dp_check)`.
  - `term`=0: `dp_run`=1 and `iter_cnt`←`iter_cnt`+1.
  - `term`=1: `dp_run`=0; capture `out_res`←`dp_dec`, `out_err`←`dp_check`, `out_iters`←`iter_cnt`; move to DONE.
- Zero iterations are never reported. `dp_check` is ignored while `iter_cnt`=0, because the core has no valid decisions yet.
- If parity is satisfied exactly at `MAX_ITER`, the result is `out_err`=0, `out_iters`=`MAX_ITER`.
- DONE: `out_valid`=1. `out_res`, `out_err` and `out_iters` are held stable until `out_valid`&`out_ready`, then the FSM moves to IDLE.
- `in_valid` is ignored outside IDLE. `out_res`, `out_err` and `out_iters` keep their last values in IDLE.
- `iter_cnt` never exceeds `MAX_ITER`; it does not wrap.

## Timing
- Reset edge: state←IDLE, `iter_cnt`←0, `dp_sig`/`out_res`/`out_iters`←0, `out_err`←0.
  - While `rst` is high, `in_ready` is forced 0.
  - After reset deasserts: `in_ready`=1 and `dp_load`/`dp_run`/`out_valid`/`busy`=0.
- Reset mid-frame (LOAD, RUN or DONE): the frame is abandoned with no `out_valid`. `dp_run` is 0 from the cycle after the reset edge.
- Input accepted at edge T: LOAD occupies cycle T+1 and RUN starts at cycle T+2.
- After k iterations (`dp_run` high for cycles T+2 .. T+1+k), `term` is evaluated in cycle T+2+k. `out_valid` rises in cycle T+3+k.
- Best case (k=1): `out_valid` 4 cycles after accept. Worst case: `MAX_ITER`+3 cycles.
- Back-to-back frames: handshake at edge E in DONE gives IDLE at E+1. A new frame can be accepted at the E+1 edge.

## Configuration
- `LDPC_EARLY_TERM_EN` defined: `term` is as given above; a clean syndrome stops decoding early.
- `LDPC_EARLY_TERM_EN` undefined: `term = (iter_cnt==MAX_ITER)` only. Every frame runs exactly `MAX_ITER` iterations, `out_iters`=`MAX_ITER`, and `out_err`=`dp_check` at stop.

## Test plan
- Early convergence (macro on, `MAX_ITER`=32): model `dp_check` falls after 3 iterations.
  - Required: `dp_load` pulses once, `dp_run` high exactly 3 cycles.
  - Required: `out_valid` 6 cycles after accept, `out_iters`=3, `out_err`=0, `out_res`=model `dp_dec`.
- Non-convergence: `dp_check` held 1.
  - Required: 32 `dp_run` cycles, then `out_iters`=32, `out_err`=1.
  - Required: `out_valid` at accept+35.
- Output backpressure: `out_ready`=0 for 10 cycles in DONE.
  - Required: `out_valid` and all outputs stable, `in_ready`=0, and `in_valid` pulses are ignored.
  - After release, the next frame is accepted 1 cycle after the handshake.
- Reset mid-RUN: assert `rst` after 5 iterations.
  - Required: `dp_run`=0 next cycle, no `out_valid`, `out_err`=0, `out_iters`=0.
  - Required: `in_ready`=1 after `rst` deasserts.
- Macro off, `MAX_ITER`=4, `dp_check` falls after 1 iteration.
  - Required: `dp_run` high 4 cycles, `out_iters`=4, `out_err`=0.
- Ignored check at zero: `dp_check`=0 while `iter_cnt`=0 (macro on).
  - Required: at least 1 iteration still runs, `out_iters`=1.
